// File: rtl/button_debounce_fsm.sv
// -----------------------------------------------------------------------------
// button_debounce_fsm
//
// Debounces one raw mechanical button (arm jog / PWM duty adjust). The pin is
// brought into the clk domain by a two-flop synchronizer. The FSM looks at the
// synchronized level only on sample_tick strobes from the debounce tick
// counter. A level change is committed after N_STABLE consecutive ticks agree
// with the new level. A disagreeing tick during qualification aborts the
// change and is counted as a bounce.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   STABLE_LO | committed level 0, waiting for a tick that sees 1
//   CHECK_HI  | qualifying a 0->1 change, cnt_q counts agreeing ticks
//   STABLE_HI | committed level 1, waiting for a tick that sees 0
//   CHECK_LO  | qualifying a 1->0 change, cnt_q counts agreeing ticks
//
// Parameters:
//   N_STABLE   - consecutive agreeing ticks needed to commit (2..255)
//   IDLE_LEVEL - released button level; reset value of sync flops and level
//
// Ports:
//   clk         - system clock
//   rst_s_p     - synchronous active-high reset
//   sample_tick - one-cycle sample strobe
//   btn_in      - raw asynchronous button pin
//   btn_level   - debounced level (registered)
//   btn_rise    - one-cycle pulse on the cycle btn_level first shows 1
//   btn_fall    - one-cycle pulse on the cycle btn_level first shows 0
//   bounce_cnt  - saturating count of aborted transitions
// -----------------------------------------------------------------------------
module button_debounce_fsm #(
  parameter int unsigned N_STABLE   = 4,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_s_p,
  input  logic       sample_tick,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic [7:0] bounce_cnt
);

  localparam int unsigned CNT_W = (N_STABLE > 1) ? $clog2(N_STABLE) : 1;
  // cnt_q holds the number of agreeing ticks already seen; the tick that
  // finds it at CNT_LAST is the N_STABLE-th one and commits the change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       BOUNCE_MAX = 8'hFF;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHECK_HI  = 2'b01,
    STABLE_HI = 2'b10,
    CHECK_LO  = 2'b11
  } state_t;

  localparam state_t RST_STATE = IDLE_LEVEL ? STABLE_HI : STABLE_LO;

  logic             sync_meta_q, sync_meta_d;
  logic             sync_q, sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       bounce_q, bounce_d;
  logic             bounce_hit;

  // Synchronizer: sync_q is the only view of the pin the FSM ever uses.
  always_comb begin
    sync_meta_d = btn_in;
    sync_d      = sync_meta_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    bounce_hit = 1'b0;

    // Between ticks nothing moves, so glitches that come and go between
    // two strobes never reach the state or counter.
    case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (sample_tick && sync_q) begin
          state_d = CHECK_HI;
          cnt_d   = CNT_ONE;
        end
      end

      CHECK_HI: begin
        if (sample_tick) begin
          if (sync_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = STABLE_HI;
              cnt_d   = '0;
              level_d = 1'b1;
              rise_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d    = STABLE_LO;
            cnt_d      = '0;
            bounce_hit = 1'b1;
          end
        end
      end

      STABLE_HI: begin
        cnt_d = '0;
        if (sample_tick && !sync_q) begin
          state_d = CHECK_LO;
          cnt_d   = CNT_ONE;
        end
      end

      CHECK_LO: begin
        if (sample_tick) begin
          if (!sync_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = STABLE_LO;
              cnt_d   = '0;
              level_d = 1'b0;
              fall_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d    = STABLE_HI;
            cnt_d      = '0;
            bounce_hit = 1'b1;
          end
        end
      end

      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
        level_d = IDLE_LEVEL;
      end
    endcase
  end

  // Bounce counter sticks at full scale until the next reset.
  always_comb begin
    bounce_d = bounce_q;
    if (bounce_hit && (bounce_q != BOUNCE_MAX)) begin
      bounce_d = bounce_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_s_p) begin
      sync_meta_q <= IDLE_LEVEL;
      sync_q      <= IDLE_LEVEL;
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      level_q     <= IDLE_LEVEL;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      bounce_q    <= 8'd0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      bounce_q    <= bounce_d;
    end
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign bounce_cnt = bounce_q;

endmodule

// File: doc/button_debounce_fsm.md
Name: button_debounce_fsm

Overview:
Consumer stage of the debounce tick counter. It samples a raw mechanical button input (arm jog / PWM duty adjust buttons) on each `sample_tick` pulse, which is the counter's match output. A level change is committed only after `N_STABLE` consecutive ticks agree. Outputs are a clean level, one-cycle rise/fall pulses for the PWM control logic, and a saturating count of rejected bounces for bring-up diagnostics.

Parameters:
N_STABLE, 4, consecutive agreeing ticks needed to commit a change; legal range 2..255
IDLE_LEVEL, 0, released (inactive) button level; reset value of synchronizer and `btn_level`

Ports:
clk  input  1  system clock
rst_s_p  input  1  reset, synchronous, active-high
sample_tick  input  1  one-cycle sample strobe from the debounce tick counter
btn_in  input  1  raw asynchronous button pin
btn_level  output  1  debounced level, registered
btn_rise  output  1  one-cycle pulse when `btn_level` goes 0->1
btn_fall  output  1  one-cycle pulse when `btn_level` goes 1->0
bounce_cnt  output  8  saturating count of aborted transitions

Behaviour:
- Single clock; all flops update on posedge `clk`.
- Reset is synchronous, active-high, and overrides everything, including mid-check:
  - state = STABLE at `IDLE_LEVEL`; check counter = 0.
  - both synchronizer flops = `IDLE_LEVEL`; `btn_level` = `IDLE_LEVEL`.
  - `btn_rise` = `btn_fall` = 0; `bounce_cnt` = 0.
  - No pulse is generated by reset.
- Synchronizer: 2-flop chain on `btn_in`. `s` = second flop output, the only value the FSM reads.
- Check counter: `ceil(log2(N_STABLE))` bits wide.
- States: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
- STABLE_LO:
  - tick & s=1 -> CHECK_HI, cnt=1.
  - Otherwise hold, cnt=0.
- CHECK_HI:
  - tick & s=1 & cnt=N_STABLE-1 -> STABLE_HI, cnt=0, `btn_level`<=1, `btn_rise`<=1.
  - tick & s=1 & cnt<N_STABLE-1 -> cnt++.
  - tick & s=0 -> STABLE_LO, cnt=0, `bounce_cnt`++ (saturating).
  - No tick -> hold state and cnt, regardless of `s`.
- STABLE_HI and CHECK_LO: mirror image, with `btn_fall`.
- Pulses: `btn_rise`/`btn_fall` are high exactly on the clock where `btn_level` first shows the new value; low on all other cycles; never both high.
- Non-tick cycles: `s` is ignored entirely. Glitches between ticks are invisible.
- Tick arriving on the same edge `s` changes: the FSM uses the pre-edge registered `s`.
- `bounce_cnt` saturates at 255 and holds; cleared only by reset.
- Latency, input step to `btn_level`: 2 clk (sync), then the `N_STABLE`-th subsequent tick, +1 clk register. With tick period T clocks, the worst case is 3 + N_STABLE*T clocks.
- `sample_tick` held high continuously is legal: every cycle is a sample, so commit happens after `N_STABLE` clocks.
- Wrap-around: cnt never exceeds N_STABLE-1. No overflow path.

Test Plan:
1. Reset: `rst_s_p`=1 for 2 clk while `btn_in`=1 -> after release `btn_level`=0, `btn_rise`=`btn_fall`=0, `bounce_cnt`=0; `btn_rise` follows only after 4 agreeing ticks.
2. Clean press, N_STABLE=4, tick every 10 clk, `btn_in` 0->1 held -> `btn_level`=1 one clk after the 4th tick following sync; `btn_rise` high for exactly 1 clk; `bounce_cnt`=0.
3. Bounce: `btn_in`=1 for 2 ticks, then 0 at the 3rd tick -> `btn_level` stays 0, no pulses, `bounce_cnt`=1. Repeat 300 times -> `bounce_cnt`=255 and holds.
4. Release from STABLE_HI: `btn_in` 1->0 held 4 ticks -> `btn_level`=0, `btn_fall` one-cycle pulse, `btn_rise` stays 0.
5. Inter-tick glitch: `btn_in` pulses high for 3 clk strictly between ticks (tick period 10) -> no state change, `bounce_cnt` unchanged.
6. Reset mid-check: in CHECK_HI with cnt=2, assert `rst_s_p` 1 clk -> next cycle STABLE_LO, `btn_level`=0, no `btn_rise`; with `btn_in` still 1, a full 4-tick qualification is required again.
